// File: rtl/bin2bcd_seg.sv
// rtl/bin2bcd_seg.sv - sequential binary-to-BCD converter with 4-digit seven-segment encoder
//
// Captures an unsigned word and its error flag on start, converts it using
// shift-add-3 (double-dabble), one bit per cycle. It then loads registered BCD
// digits and active-low segment patterns, blanking leading zeros.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     conversion request, sampled only while idle
//   bin       unsigned value to convert (WIDTH bits, 1..13), sampled with start
//   err       error flag, sampled with start; shows dashes on all digits
//   busy      high while a conversion is in progress
//   done      one-cycle pulse when bcd/seg_* take their new values
//   bcd       {thousands, hundreds, tens, units}, 4 bits each
//   seg_1 .. seg_1000  active-low segments, bit0 = a .. bit6 = g
module bin2bcd_seg #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    input  logic             err,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd,
    output logic [6:0]       seg_1,
    output logic [6:0]       seg_10,
    output logic [6:0]       seg_100,
    output logic [6:0]       seg_1000
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LOAD
    } state_t;

    state_t              state;
    // {BCD scratch, remaining binary bits}, shifted left as one vector
    logic [15+WIDTH:0]   work;
    logic [CW-1:0]       cnt;
    logic                err_q;

    logic [15:0]         scratch;
    logic [15:0]         scratch_adj;
    logic [15+WIDTH:0]   work_next;
    logic                blank_1000;
    logic                blank_100;
    logic                blank_10;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    always_comb begin
        scratch     = work[15+WIDTH:WIDTH];
        scratch_adj = scratch;
        // Correct each nibble before the shift so it carries cleanly past 9
        for (int i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        work_next = {scratch_adj, work[WIDTH-1:0]} << 1;

        // A digit blanks only when it and every more-significant digit are zero
        blank_1000 = (scratch[15:12] == 4'd0);
        blank_100  = blank_1000 && (scratch[11:8] == 4'd0);
        blank_10   = blank_100  && (scratch[7:4]  == 4'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            work     <= '0;
            cnt      <= '0;
            err_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= 16'h0000;
            seg_1    <= SEG_ZERO;
            seg_10   <= SEG_BLANK;
            seg_100  <= SEG_BLANK;
            seg_1000 <= SEG_BLANK;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        work  <= {16'h0000, bin};
                        err_q <= err;
                        cnt   <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    work <= work_next;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    bcd  <= scratch;
                    done <= 1'b1;
                    busy <= 1'b0;
                    if (err_q) begin
                        seg_1    <= SEG_DASH;
                        seg_10   <= SEG_DASH;
                        seg_100  <= SEG_DASH;
                        seg_1000 <= SEG_DASH;
                    end else begin
                        seg_1    <= seg_of(scratch[3:0]);
                        seg_10   <= blank_10   ? SEG_BLANK : seg_of(scratch[7:4]);
                        seg_100  <= blank_100  ? SEG_BLANK : seg_of(scratch[11:8]);
                        seg_1000 <= blank_1000 ? SEG_BLANK : seg_of(scratch[15:12]);
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/bin2bcd_seg.md
# bin2bcd_seg

Sequential binary-to-BCD converter and seven-segment encoder sitting directly downstream of the arithmetic top level. It captures an unsigned result word and its error flag on a `start` strobe. It converts the word with a shift-add-3 (double-dabble) sequence and drives four registered, active-low seven-segment digit outputs with leading-zero blanking. On error, the outputs show an error pattern instead.

## Interface
- `WIDTH`, default 12: binary input width; legal range 1..13, so the result always fits in 4 decimal digits.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `bin` input WIDTH: unsigned value to display; sampled with `start`.
- `err` input 1: arithmetic error flag; sampled with `start`.
- `busy` output 1: high while a conversion is in progress (SHIFT or LOAD).
- `done` output 1: one-cycle pulse when new display values take effect.
- `bcd` output 16: registered packed digits {thousands, hundreds, tens, units}, 4 bits each.
- `seg_1`, `seg_10`, `seg_100`, `seg_1000` output 7 each: registered, active-low segments, bit0 = a … bit6 = g.

## Operation
- **States:**
  - IDLE → SHIFT when `start` is high. That edge loads a shift register with `bin`, latches `err`, clears the 16-bit BCD scratch and sets the bit counter to WIDTH.
  - SHIFT, one bit per cycle. First, each scratch nibble ≥ 5 gets +3. Then {scratch, shreg} shifts left by 1, bringing in the `bin` MSB. The counter decrements, and the state goes to LOAD when the counter reaches 1.
  - LOAD → IDLE unconditionally. This edge updates `bcd` and all `seg_*` and raises `done` for exactly one cycle.
- **Segment encoding, active-low gfedcba:**
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - blank = 1111111, dash = 0111111
- **Leading-zero blanking:**
  - A digit is blanked when it and every more-significant digit are 0.
  - The units digit is never blanked.
  - Embedded zeros are shown, e.g. 1000 → "1000" and 205 → " 205".
- **Error handling:**
  - If the latched `err` = 1, all four `seg_*` show dash.
  - `bcd` still holds the converted value of `bin`.
  - Conversion still runs for its full length, and timing is identical.
- **Start while busy:**
  - `start` asserted in SHIFT or LOAD is ignored; there is no queuing.
  - `bin` and `err` may change freely after the `start` cycle.
- **Between conversions:** outputs hold their last values until the next LOAD.
- **Arithmetic:** unsigned only. Since WIDTH ≤ 13 (maximum 8191), there is no BCD overflow. No add-3 correction is applied after the final shift.

## Timing
- **Reset values:**
  - state IDLE, `busy` = 0, `done` = 0, `bcd` = 0
  - `seg_1` = 1000000 ("0")
  - `seg_10`, `seg_100`, `seg_1000` = 1111111 (blank)
- **Latency:** `start` sampled high at edge 0 gives:
  - `busy` = 1 after edge 0
  - SHIFT for edges 1..WIDTH
  - LOAD after edge WIDTH; outputs update and `done` = 1 after edge WIDTH+1
  - `busy` = 0 after edge WIDTH+1
  - Total WIDTH+1 cycles from start to `done`; for WIDTH = 12, `done` is visible 13 cycles after the start edge.
- **Back-to-back:** `start` is accepted in the same cycle `done` is high (state is IDLE), so the minimum period is WIDTH+2 cycles.
- **Asynchronous `rst`:** asserting it at any time, including mid-SHIFT, immediately forces all reset values and aborts the conversion. The first accepted `start` after deassertion behaves normally.
- **Glitch-free outputs:** all outputs come directly from flops, with no combinational path from inputs to outputs.

## Test plan
- Reset, then `start` with `bin` = 0, `err` = 0 → `done` 13 cycles later; `bcd` = 0x0000; segs = blank, blank, blank, 1000000.
- `bin` = 4095 → `bcd` = 0x4095; `seg_1000` = 0011001, `seg_100` = 1000000, `seg_10` = 0010000, `seg_1` = 0010010; `busy` high for exactly 13 cycles.
- `bin` = 205, then `bin` = 1000 back-to-back (second `start` in the `done` cycle) → " 205", then "1000" with embedded zeros shown; second `done` 14 cycles after the first.
- `bin` = 37, `err` = 1 → all segs = 0111111; `bcd` = 0x0037; `done` timing unchanged.
- `start` with 123; pulse `start` with 999 at cycle 5 → ignored; result is 0x0123 with a single `done` pulse.
- Assert `rst` at cycle 6 of a conversion of 4000 → immediate reset values, no `done`; a subsequent `start` with 4000 → "4000".
